// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shift-add multiply and
// one-bit-per-cycle left shift, with a valid/ready handshake on both sides.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Handshake: an operation transfers on an edge with in_valid & in_ready (IDLE only);
    // a result transfers on an edge with out_valid & out_ready (DONE only).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             last_step;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [2:0]       op_r;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   limit;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] mul_next;
    logic [WIDTH-1:0] busy_res;

    assign dbg_state = state;
    assign last_step = (cnt == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op == OP_MUL || (op == OP_SLL && B[SHW-1:0] != '0)) begin
                        next_state = BUSY;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            BUSY: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Single-cycle ops are evaluated straight from the inputs on the accept edge.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_ADD: begin
                sum_ext = {1'b0, A} + {1'b0, B};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: alu_res = A;
            default: alu_res = '0;
        endcase
    end

    // a_r doubles as the shifting multiplicand / shift operand, b_r as the consumed multiplier.
    assign mul_next = b_r[0] ? (acc + a_r) : acc;
    assign busy_res = (op_r == OP_MUL) ? mul_next : (a_r << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            op_r     <= '0;
            cnt      <= '0;
            limit    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= A;
                        b_r   <= B;
                        op_r  <= op;
                        acc   <= '0;
                        cnt   <= '0;
                        limit <= (op == OP_MUL) ? MUL_LAST : (B[SHW-1:0] - 1'b1);
                        if (next_state == DONE) begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            carry    <= alu_c;
                            overflow <= alu_v;
                        end
                    end
                end
                BUSY: begin
                    a_r <= a_r << 1;
                    cnt <= cnt + 1'b1;
                    if (op_r == OP_MUL) begin
                        acc <= mul_next;
                        b_r <= b_r >> 1;
                    end
                    if (last_step) begin
                        result   <= busy_res;
                        zero     <= (busy_res == '0);
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed corner vectors plus random operations checked
// against an arithmetic reference model, including latency, backpressure and reset.
module tb_alu_multicycle;

    localparam int W   = 32;
    localparam int SHW = $clog2(W);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .carry(carry), .overflow(overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operand values.
    task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] res, output logic c, output logic v,
                             output int lat);
        longint sa, sb, ss;
        longint smax, smin;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        smax = (longint'(1) << (W-1)) - 1;
        smin = -(longint'(1) << (W-1));
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        res = '0;
        case (o)
            3'd0: res = a & b;
            3'd1: begin
                res = a + b;
                c = ((longint'(a) + longint'(b)) >= (longint'(1) << W));
                ss = sa + sb;
                v = (ss > smax) || (ss < smin);
            end
            3'd2: begin
                res = a - b;
                c = (a >= b);
                ss = sa - sb;
                v = (ss > smax) || (ss < smin);
            end
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 1 : 0;
            3'd6: begin
                res = a << b[SHW-1:0];
                lat = int'(b[SHW-1:0]) + 1;
            end
            default: begin
                res = a * b;
                lat = W + 1;
            end
        endcase
    endtask

    // Issue one op; returns at the negedge where out_valid is first seen (lat = -1 on timeout).
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output int lat, output int ready_hits);
        int waited;
        lat = -1;
        ready_hits = 0;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        op = o;
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noise;
        op = 3'($urandom_range(0, 7));
        A = W'($urandom);
        B = W'($urandom);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k + 1;
                in_valid = 1'b0;
                break;
            end
            if (in_ready) ready_hits++;
            if (noise) begin
                op = 3'($urandom_range(0, 7));
                A = W'($urandom);
                B = W'($urandom);
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit noise);
        logic [W-1:0] er;
        logic ec, ev;
        int elat, lat, hits;
        ref_model(o, a, b, er, ec, ev, elat);
        run_op(o, a, b, noise, lat, hits);
        n_cmp++;
        if (lat !== elat) begin
            n_bad++;
            $display("FAIL %s latency op=%0d a=%h b=%h: got %0d want %0d", name, o, a, b, lat, elat);
        end
        n_cmp++;
        if ({result, zero, carry, overflow} !== {er, (er == '0), ec, ev}) begin
            n_bad++;
            $display("FAIL %s result op=%0d a=%h b=%h: got %h z%b c%b v%b want %h z%b c%b v%b",
                     name, o, a, b, result, zero, carry, overflow, er, (er == '0), ec, ev);
        end
        n_cmp++;
        if (hits !== 0) begin
            n_bad++;
            $display("FAIL %s in_ready_while_busy: got %0d cycles want 0", name, hits);
        end
        consume();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, zero, carry, overflow} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy%b vld%b z%b c%b v%b want 1 0 0 0 0",
                     in_ready, out_valid, zero, carry, overflow);
        end
        n_cmp++;
        if (result !== '0) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 0", result);
        end
    endtask

    task automatic test_directed();
        int lat, hits;
        run_op(3'd1, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, hits);
        n_cmp++;
        if ({lat, result, zero, carry, overflow} !== {32'd1, 32'h8000_0000, 3'b001}) begin
            n_bad++;
            $display("FAIL add_ovf: got lat%0d %h z%b c%b v%b want lat1 80000000 z0 c0 v1",
                     lat, result, zero, carry, overflow);
        end
        consume();
        run_op(3'd2, 32'd5, 32'd5, 1'b0, lat, hits);
        n_cmp++;
        if ({result, zero, carry, overflow} !== {32'h0, 3'b110}) begin
            n_bad++;
            $display("FAIL sub_eq: got %h z%b c%b v%b want 0 z1 c1 v0", result, zero, carry, overflow);
        end
        consume();
        run_op(3'd5, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, hits);
        n_cmp++;
        if (result !== 32'h1) begin
            n_bad++;
            $display("FAIL slt_neg: got %h want 1", result);
        end
        consume();
        run_op(3'd7, 32'h0000_FFFF, 32'h0001_0001, 1'b1, lat, hits);
        n_cmp++;
        if ({lat, result, hits} !== {32'd33, 32'hFFFF_FFFF, 32'd0}) begin
            n_bad++;
            $display("FAIL mul_vec: got lat%0d %h rdyhits%0d want lat33 ffffffff rdyhits0",
                     lat, result, hits);
        end
        consume();
        run_op(3'd6, 32'h1, 32'd31, 1'b1, lat, hits);
        n_cmp++;
        if ({lat, result} !== {32'd32, 32'h8000_0000}) begin
            n_bad++;
            $display("FAIL sll_31: got lat%0d %h want lat32 80000000", lat, result);
        end
        consume();
        run_op(3'd6, 32'h1234, 32'h20, 1'b0, lat, hits);
        n_cmp++;
        if ({lat, result} !== {32'd1, 32'h1234}) begin
            n_bad++;
            $display("FAIL sll_0: got lat%0d %h want lat1 00001234", lat, result);
        end
        consume();
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = W'($urandom);
            b = W'($urandom);
            if (i % 5 == 0) b = a;
            if (i % 7 == 0) a = W'(32'h8000_0000);
            check_op("random", o, a, b, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int lat, hits;
        logic [W-1:0] r0;
        logic [2:0] f0;
        int bad;
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, lat, hits);
        r0 = result;
        f0 = {zero, carry, overflow};
        bad = 0;
        in_valid = 1'b1;
        op = 3'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (result !== r0 || {zero, carry, overflow} !== f0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        n_cmp++;
        if ({r0, f0} !== {32'h1, 3'b010}) begin
            n_bad++;
            $display("FAIL bp_value: got %h zcv=%b want 00000001 zcv=010", r0, f0);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        consume();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release: got rdy%b vld%b want rdy1 vld0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midop();
        int lat, hits;
        @(negedge clk);
        op = 3'd7;
        A = W'($urandom);
        B = W'($urandom);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        pulse_reset();
        n_cmp++;
        if ({out_valid, in_ready, result} !== {2'b01, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_mul: got vld%b rdy%b %h want vld0 rdy1 0", out_valid, in_ready, result);
        end
        run_op(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat, hits);
        n_cmp++;
        if ({lat, result} !== {32'd1, 32'hF000_F000}) begin
            n_bad++;
            $display("FAIL and_after_rst: got lat%0d %h want lat1 f000f000", lat, result);
        end
        pulse_reset();
        n_cmp++;
        if ({out_valid, in_ready, result, zero} !== {2'b01, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_done: got vld%b rdy%b %h z%b want vld0 rdy1 0 z0",
                     out_valid, in_ready, result, zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat, hits;
        run_op(3'd4, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b0, lat, hits);
        // A new request offered on the consuming edge must not be taken on that edge.
        in_valid = 1'b1;
        op = 3'd3;
        A = 32'h1;
        B = 32'h2;
        consume();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, result} !== {2'b10, 32'hA5A5_5A5A}) begin
            n_bad++;
            $display("FAIL b2b_no_accept: got rdy%b vld%b %h want rdy1 vld0 a5a55a5a",
                     in_ready, out_valid, result);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, zero} !== {1'b1, 32'h3, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_second: got vld%b %h z%b want vld1 00000003 z0", out_valid, result, zero);
        end
        consume();
        check_op("b2b_mul", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_op("b2b_sll", 3'd6, 32'hDEAD_BEEF, 32'd4, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        A = '0;
        B = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
